// File: rtl/LoadStoreUnitTypes.sv
// Shared load/store unit types: address/data paths, drain-buffer entry, FSM states.
package LoadStoreUnitTypes;

  typedef logic [29:0] LSQ_BlockAddrPath;       // word-granular block address
  typedef logic [31:0] LSQ_BlockDataPath;
  typedef logic [3:0]  LSQ_WordByteEnablePath;
  typedef logic [31:0] PhyAddrPath;

  localparam int STORE_DRAIN_DEPTH     = 4;
  localparam int LOCK_CYCLES_TO_REPLAY = 5;

  typedef struct packed {
    LSQ_BlockAddrPath      addr;
    LSQ_BlockDataPath      data;
    LSQ_WordByteEnablePath byteWE;
  } StoreDrainEntry;

  typedef enum logic [1:0] {
    SDB_IDLE    = 2'd0,
    SDB_REQ     = 2'd1,
    SDB_BACKOFF = 2'd2
  } StoreDrainState;

  // Block address -> byte address of the word
  function automatic PhyAddrPath LSQ_ToFullAddrFromBlockAddr(input LSQ_BlockAddrPath a);
    return {a, 2'b00};
  endfunction

endpackage

// File: rtl/store_drain_forward_select.sv
// Per-byte store-to-load forwarding: youngest matching valid entry wins per byte.
module store_drain_forward_select
  import LoadStoreUnitTypes::*;
#(
  parameter int DEPTH = 4
) (
  input  StoreDrainEntry        entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  LSQ_BlockAddrPath      ld_addr,
  output LSQ_WordByteEnablePath byte_hit,
  output LSQ_BlockDataPath      data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] idx;

  // Walk oldest -> youngest so a younger match overwrites an older one per byte
  always_comb begin
    byte_hit = '0;
    data     = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + IDX_W'(i);
      if (((IDX_W+1)'(i) < count) && (entries[idx].addr == ld_addr)) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].byteWE[b]) begin
            byte_hit[b]    = 1'b1;
            data[8*b +: 8] = entries[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_drain_buffer.sv
// Committed-store FIFO draining to the D-cache with miss backoff and load forwarding.
module store_drain_buffer
  import LoadStoreUnitTypes::*;
#(
  parameter int DEPTH        = STORE_DRAIN_DEPTH,
  parameter int RETRY_CYCLES = LOCK_CYCLES_TO_REPLAY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commitValid,
  input  LSQ_BlockAddrPath      commitAddr,
  input  LSQ_BlockDataPath      commitData,
  input  LSQ_WordByteEnablePath commitByteWE,
  output logic                  commitReady,
  output logic                  dcWrReq,
  output PhyAddrPath            dcWrAddr,
  output LSQ_BlockDataPath      dcWrData,
  output LSQ_WordByteEnablePath dcWrByteWE,
  input  logic                  dcWrAck,
  input  logic                  dcWrMiss,
  input  LSQ_BlockAddrPath      ldAddr,
  output LSQ_WordByteEnablePath fwdByteHit,
  output LSQ_BlockDataPath      fwdData,
  output logic                  empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RETRY_CYCLES + 1);

  StoreDrainEntry   mem [DEPTH];
  logic [IDX_W:0]   head_ptr, tail_ptr, count, count_next;
  StoreDrainState   state;
  logic [CNT_W-1:0] retry_cnt;
  logic             fifo_empty, full, push, pop;
  StoreDrainEntry   head_entry;

  assign count       = tail_ptr - head_ptr;
  assign fifo_empty  = (head_ptr == tail_ptr);
  assign full        = (head_ptr[IDX_W] != tail_ptr[IDX_W]) &&
                       (head_ptr[IDX_W-1:0] == tail_ptr[IDX_W-1:0]);
  // Ready comes only from registered pointers, so a same-cycle pop cannot open a full FIFO
  assign commitReady = !full;
  assign push        = commitValid && commitReady;
  assign pop         = (state == SDB_REQ) && dcWrAck;
  assign count_next  = count - (IDX_W+1)'(pop) + (IDX_W+1)'(push);
  assign head_entry  = mem[head_ptr[IDX_W-1:0]];

  // Entry storage: write at tail on accept; contents need no reset since validity lives in the pointers
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[tail_ptr[IDX_W-1:0]] <= '{addr: commitAddr, data: commitData, byteWE: commitByteWE};
  end

  // Head/tail pointers with wrap bit
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
    end
  end

  // Drain FSM: BACKOFF spends RETRY_CYCLES cycles (counter RETRY_CYCLES-1 down to 0)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SDB_IDLE;
      retry_cnt <= '0;
    end else begin
      case (state)
        SDB_IDLE:    if (!fifo_empty) state <= SDB_REQ;
        SDB_REQ: begin
          if (dcWrAck) begin
            state <= (count_next != '0) ? SDB_REQ : SDB_IDLE;
          end else if (dcWrMiss) begin
            retry_cnt <= CNT_W'(RETRY_CYCLES - 1);
            state     <= SDB_BACKOFF;
          end
        end
        SDB_BACKOFF: begin
          if (retry_cnt == '0) state <= SDB_REQ;
          else                 retry_cnt <= retry_cnt - CNT_W'(1);
        end
        default:     state <= SDB_IDLE;
      endcase
    end
  end

  assign dcWrReq    = (state == SDB_REQ);
  assign dcWrAddr   = dcWrReq ? LSQ_ToFullAddrFromBlockAddr(head_entry.addr) : '0;
  assign dcWrData   = dcWrReq ? head_entry.data   : '0;
  assign dcWrByteWE = dcWrReq ? head_entry.byteWE : '0;
  assign empty      = fifo_empty && (state == SDB_IDLE);

  store_drain_forward_select #(.DEPTH(DEPTH)) u_fwd (
    .entries  (mem),
    .head     (head_ptr[IDX_W-1:0]),
    .count    (count),
    .ld_addr  (ldAddr),
    .byte_hit (fwdByteHit),
    .data     (fwdData)
  );

endmodule

// File: tb/tb_store_drain_buffer.sv
// Self-checking bench: queue-based reference model plus directed scenarios and random traffic.
module tb_store_drain_buffer;
  import LoadStoreUnitTypes::*;

  localparam int DEPTH = 4;
  localparam int RETRY = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  commitValid = 1'b0;
  LSQ_BlockAddrPath      commitAddr = '0;
  LSQ_BlockDataPath      commitData = '0;
  LSQ_WordByteEnablePath commitByteWE = '0;
  logic                  commitReady;
  logic                  dcWrReq;
  PhyAddrPath            dcWrAddr;
  LSQ_BlockDataPath      dcWrData;
  LSQ_WordByteEnablePath dcWrByteWE;
  logic                  dcWrAck = 1'b0;
  logic                  dcWrMiss = 1'b0;
  LSQ_BlockAddrPath      ldAddr = '0;
  LSQ_WordByteEnablePath fwdByteHit;
  LSQ_BlockDataPath      fwdData;
  logic                  empty;

  store_drain_buffer #(.DEPTH(DEPTH), .RETRY_CYCLES(RETRY)) dut (
    .clk(clk), .rst(rst),
    .commitValid(commitValid), .commitAddr(commitAddr), .commitData(commitData),
    .commitByteWE(commitByteWE), .commitReady(commitReady),
    .dcWrReq(dcWrReq), .dcWrAddr(dcWrAddr), .dcWrData(dcWrData), .dcWrByteWE(dcWrByteWE),
    .dcWrAck(dcWrAck), .dcWrMiss(dcWrMiss),
    .ldAddr(ldAddr), .fwdByteHit(fwdByteHit), .fwdData(fwdData), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: ordered queue of pending stores, a "draining" flag and a backoff wait
  StoreDrainEntry q[$];
  bit  busy;
  int  wait_left;
  int  ack_mode;      // 0 hold, 1 always ack, 2 random ack/miss/hold, 3 one miss then ack
  bit  miss_pending;

  logic        req_trace[$];
  logic        empty_trace[$];
  logic [31:0] addr_trace[$];
  logic [29:0] ack_log[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_traces();
    req_trace.delete(); empty_trace.delete(); addr_trace.delete(); ack_log.delete();
  endtask

  // One clock cycle: drive at negedge, compare against model, advance model at posedge
  task automatic cycle(input bit v, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [29:0] ld);
    bit exp_req, do_ack, do_miss, pushed, was_nonempty;
    logic [3:0]  eh;
    logic [31:0] ed;
    int r;
    @(negedge clk);
    exp_req = busy && (wait_left == 0);
    do_ack = 0; do_miss = 0;
    if (exp_req) begin
      case (ack_mode)
        1: do_ack = 1;
        2: begin
          r = int'($urandom_range(0, 3));
          do_miss = (r == 0);
          do_ack  = (r >= 2);
        end
        3: begin
          if (miss_pending) begin do_miss = 1; miss_pending = 0; end
          else do_ack = 1;
        end
        default: ;
      endcase
    end
    commitValid = v; commitAddr = a; commitData = d; commitByteWE = be;
    dcWrAck = do_ack; dcWrMiss = do_miss; ldAddr = ld;
    #1;
    eh = '0; ed = '0;
    foreach (q[i]) begin
      if (q[i].addr == ld) begin
        for (int b = 0; b < 4; b++)
          if (q[i].byteWE[b]) begin eh[b] = 1'b1; ed[8*b +: 8] = q[i].data[8*b +: 8]; end
      end
    end
    chk("commitReady", commitReady, q.size() < DEPTH);
    chk("dcWrReq", dcWrReq, exp_req);
    chk("empty", empty, (q.size() == 0) && !busy);
    if (exp_req) begin
      chk("dcWrAddr", dcWrAddr, {q[0].addr, 2'b00});
      chk("dcWrData", dcWrData, q[0].data);
      chk("dcWrByteWE", dcWrByteWE, q[0].byteWE);
    end else begin
      chk("payload_idle", {dcWrAddr, dcWrData, dcWrByteWE}, 68'h0);
    end
    chk("fwdByteHit", fwdByteHit, eh);
    chk("fwdData", fwdData, ed);
    req_trace.push_back(dcWrReq);
    empty_trace.push_back(empty);
    addr_trace.push_back(dcWrAddr);
    if (dcWrReq && do_ack) ack_log.push_back(dcWrAddr[31:2]);
    @(posedge clk);
    pushed       = v && (q.size() < DEPTH);
    was_nonempty = (q.size() != 0);
    if (exp_req && do_ack) void'(q.pop_front());
    if (pushed) q.push_back('{addr: a, data: d, byteWE: be});
    if (busy) begin
      if (exp_req && do_ack)       busy = (q.size() != 0);
      else if (exp_req && do_miss) wait_left = RETRY;
      else if (wait_left > 0)      wait_left--;
    end else if (was_nonempty) begin
      busy = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 30'h40);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; commitValid = 0; dcWrAck = 0; dcWrMiss = 0;
    @(posedge clk);
    q.delete(); busy = 0; wait_left = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_commitReady", commitReady, 1'b1);
    chk("rst_dcWrReq", dcWrReq, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_fwdByteHit", fwdByteHit, 4'b0);
    chk("rst_payload", {dcWrAddr, dcWrData, dcWrByteWE}, 68'h0);
  endtask

  initial begin
    int f, zeros, k;
    busy = 0; wait_left = 0; ack_mode = 0; miss_pending = 0;

    // Reset state
    do_reset();

    // Single store, ack held: req two cycles after commit, empty right after the ack
    clear_traces(); ack_mode = 1;
    cycle(1, 30'h100, 32'hAABBCCDD, 4'b1111, 30'h100);
    idle(3);
    chk("single_req_c1", req_trace[1], 1'b0);
    chk("single_req_c2", req_trace[2], 1'b1);
    chk("single_addr", addr_trace[2], 32'h400);
    chk("single_empty_c3", empty_trace[3], 1'b1);

    // Fill to full, 5th commit refused, drain in order
    do_reset(); clear_traces(); ack_mode = 0;
    for (int i = 0; i < 4; i++) cycle(1, 30'h10 + 30'(i), 32'h1000 + 32'(i), 4'b1111, 30'h0);
    cycle(1, 30'h999, 32'hDEAD, 4'b1111, 30'h0);
    chk("full_ready", commitReady, 1'b0);
    ack_mode = 1;
    idle(6);
    chk("order_count", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      chk("order_addr", ack_log[i], 30'h10 + 30'(i));

    // Miss then reissue after exactly RETRY idle cycles
    do_reset(); clear_traces(); ack_mode = 3; miss_pending = 1;
    cycle(1, 30'h77, 32'h12345678, 4'b0101, 30'h0);
    idle(11);
    f = -1;
    for (int i = 0; i < req_trace.size(); i++) if (f < 0 && req_trace[i]) f = i;
    zeros = 0; k = f + 1;
    while (f >= 0 && k < req_trace.size() && !req_trace[k]) begin zeros++; k++; end
    chk("miss_gap", zeros, RETRY);
    chk("miss_reissue_addr", (k < addr_trace.size()) ? addr_trace[k] : 32'hFFFF_FFFF, 32'h1DC);
    chk("miss_ack_count", ack_log.size(), 1);

    // Forwarding merge of two stores to the same word
    do_reset(); clear_traces(); ack_mode = 0;
    cycle(1, 30'h40, 32'h0000_1111, 4'b0011, 30'h40);
    cycle(1, 30'h40, 32'h2222_2200, 4'b0110, 30'h40);
    cycle(0, '0, '0, '0, 30'h40);
    chk("fwd_hit", fwdByteHit, 4'b0111);
    chk("fwd_data", fwdData, 32'h0022_2211);
    ack_mode = 1;
    idle(4);

    // Reset during BACKOFF with 3 entries
    do_reset(); clear_traces(); ack_mode = 3; miss_pending = 1;
    for (int i = 0; i < 3; i++) cycle(1, 30'h80 + 30'(i), 32'(i), 4'b1111, 30'h80);
    idle(2);
    chk("backoff_before_rst", dcWrReq, 1'b0);
    do_reset();
    idle(3);

    // Steady push+ack across pointer wrap
    do_reset(); ack_mode = 0;
    cycle(1, 30'h200, 32'hA0, 4'b1111, 30'h0);
    cycle(1, 30'h201, 32'hA1, 4'b1111, 30'h0);
    clear_traces(); ack_mode = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 30'h202 + 30'(i), 32'hA2 + 32'(i), 4'b1111, 30'h0);
      chk("wrap_ready", commitReady, 1'b1);
      chk("wrap_empty", empty, 1'b0);
    end
    chk("wrap_count", ack_log.size(), 10);
    for (int i = 0; i < 10 && i < ack_log.size(); i++)
      chk("wrap_order", ack_log[i], 30'h200 + 30'(i));
    idle(4);

    // Random traffic against the model
    do_reset(); ack_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else cycle(bit'($urandom_range(0, 1)), 30'h40 + 30'($urandom_range(0, 2)),
                 $urandom, 4'($urandom_range(0, 15)), 30'h40 + 30'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
